// File: rtl/shot_scheduler.sv
// shot_scheduler: slot pool for player projectiles; spawns on shoot presses,
// enforces a frame cooldown and moves every live shot up once per frame.
// Ports: clk; rst (sync, active-high); frame_tick (one pulse per frame);
//   shoot (button level); playerx[9:0]; hit[SLOTS-1:0] (per-slot clear).
//   proj_x/proj_y[10*SLOTS-1:0] (slot i at [10i+9:10i]); exists[SLOTS-1:0];
//   fire (spawn pulse); busy (frame walk in progress); overrun (sticky).
module shot_scheduler #(
   parameter int SLOTS    = 4,
   parameter int COOLDOWN = 15,
   parameter int SPEED    = 4,
   parameter int SPAWN_Y  = 448,
   parameter int X_OFFSET = 30
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                shoot,
   input  logic [9:0]          playerx,
   input  logic [SLOTS-1:0]    hit,
   output logic [10*SLOTS-1:0] proj_x,
   output logic [10*SLOTS-1:0] proj_y,
   output logic [SLOTS-1:0]    exists,
   output logic                fire,
   output logic                busy,
   output logic                overrun
);

   localparam int SW = $clog2(SLOTS);
   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN);
   localparam logic [CW-1:0] CD_ONE   = CW'(1);
   localparam logic [SW-1:0] IDX_LAST = SW'(SLOTS - 1);
   localparam logic [SW-1:0] IDX_ONE  = SW'(1);
   localparam logic [9:0]    STEP     = 10'(SPEED);
   localparam logic [9:0]    Y_START  = 10'(SPAWN_Y);
   localparam logic [9:0]    X_OFF    = 10'(X_OFFSET);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_UPDATE = 2'd1;
   localparam logic [1:0] S_SPAWN  = 2'd2;

   logic [1:0]       r_state;
   logic [SW-1:0]    r_idx;
   logic [CW-1:0]    r_cd;
   logic             r_cd_ok;
   logic             r_pend;
   logic             r_shoot_q;
   logic             r_fire;
   logic             r_overrun;
   logic [SLOTS-1:0] r_exists;
   logic [9:0]       r_x [SLOTS];
   logic [9:0]       r_y [SLOTS];

   logic             w_rise;
   logic             w_any_free;
   logic [SW-1:0]    w_free_idx;
   logic             w_spawn;
   logic             w_update;

   // Lowest-index free slot.
   always_comb begin
      w_free_idx = '0;
      w_any_free = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!r_exists[i]) begin
            w_free_idx = SW'(i);
            w_any_free = 1'b1;
         end
      end
   end

   assign w_rise   = shoot & ~r_shoot_q;
   assign w_spawn  = (r_state == S_SPAWN) & r_pend & r_cd_ok & w_any_free;
   // A hit on the slot being walked wins: neither moved nor retired.
   assign w_update = (r_state == S_UPDATE) & r_exists[r_idx] & ~hit[r_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_cd      <= '0;
         r_cd_ok   <= 1'b0;
         r_pend    <= 1'b0;
         r_shoot_q <= 1'b0;
         r_fire    <= 1'b0;
         r_overrun <= 1'b0;
         r_exists  <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
      end else begin
         r_shoot_q <= shoot;
         r_fire    <= w_spawn;

         if (frame_tick && (r_state != S_IDLE))
            r_overrun <= 1'b1;

         unique case (r_state)
            S_IDLE: begin
               if (frame_tick) begin
                  // Eligibility uses the count as it stood when the frame
                  // began, so COOLDOWN whole frames pass between shots.
                  r_cd_ok <= (r_cd == '0);
                  if (r_cd != '0)
                     r_cd <= r_cd - CD_ONE;
                  r_idx   <= '0;
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (w_update) begin
                  if (r_y[r_idx] < STEP)
                     r_exists[r_idx] <= 1'b0;
                  else
                     r_y[r_idx] <= r_y[r_idx] - STEP;
               end
               if (r_idx == IDX_LAST)
                  r_state <= S_SPAWN;
               else
                  r_idx <= r_idx + IDX_ONE;
            end
            S_SPAWN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         for (int i = 0; i < SLOTS; i++) begin
            if (hit[i])
               r_exists[i] <= 1'b0;
         end

         // Placed after the hit clears: a hit names the old occupant.
         if (w_spawn) begin
            r_exists[w_free_idx] <= 1'b1;
            r_x[w_free_idx]      <= playerx + X_OFF;
            r_y[w_free_idx]      <= Y_START;
            r_cd                 <= CD_LOAD;
         end

         r_pend <= (r_pend & ~w_spawn) | w_rise;
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_pack
      assign proj_x[10*g +: 10] = r_x[g];
      assign proj_y[10*g +: 10] = r_y[g];
   end

   assign exists  = r_exists;
   assign fire    = r_fire;
   assign busy    = (r_state != S_IDLE);
   assign overrun = r_overrun;

endmodule
